// File: rtl/demux_serialiser_if.sv
// demux_serialiser_if: parallel word input plus the serial drive towards the 1-to-8 demux.
//
// Handshake: a word (in_data together with mask) transfers on a rising clk edge
// where in_valid and in_ready are both high. in_ready never depends on in_valid.
// While in_valid is high and the word has not transferred, the word is not
// consumed; the serialiser ignores in_data/mask whenever in_ready is low.
interface demux_serialiser_if #(
    parameter int WIDTH = 8,
    parameter int SELW  = $clog2(WIDTH)
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] mask;
    logic             d;
    logic [SELW-1:0]  sel;
    logic             strobe;
    logic             done;
    logic             busy;

    // Word source / demux consumer side.
    modport master (
        output in_data, in_valid, mask,
        input  in_ready, d, sel, strobe, done, busy
    );

    // Serialiser side.
    modport slave (
        input  in_data, in_valid, mask,
        output in_ready, d, sel, strobe, done, busy
    );
endinterface

// File: rtl/demux_serialiser.sv
// demux_serialiser: buffers one parallel word and shifts it out one enabled
// channel per clock as (d, sel, strobe) for the downstream 1-to-8 demux.
// A hold register decouples input acceptance from shifting so words can run
// back to back; disabled channels are skipped without spending cycles.
module demux_serialiser #(
    parameter int WIDTH = 8,
    parameter int SELW  = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               n_reset,
    demux_serialiser_if.slave  bus,
    output logic               dbg_state,
    output logic               dbg_hfull
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state;

    // Hold register: the next word waiting for the shifter.
    logic [WIDTH-1:0] hreg;
    logic [WIDTH-1:0] hmask;
    logic             hfull;

    // Shift register: the word currently being presented.
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] smask;
    logic [SELW-1:0]  ptr;

    logic             accept;
    logic             load;
    logic             shifting;
    logic             last;
    logic             live;
    logic [SELW-1:0]  first_ptr;
    logic [SELW-1:0]  higher_ptr;
    logic             has_higher;

    assign shifting = (state == ST_SHIFT);
    assign accept   = bus.in_valid && !hfull;

    // The pointer only ever sits on an enabled channel, except for an empty
    // mask where it stays at 0 and smask[0] is clear, so nothing is strobed.
    assign live     = shifting && smask[ptr];
    assign last     = shifting && !has_higher;
    assign load     = hfull && ((state == ST_IDLE) || last);

    // Lowest enabled channel of the held word (0 when the mask is empty).
    always_comb begin
        first_ptr = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (hmask[i]) begin
                first_ptr = i[SELW-1:0];
            end
        end
    end

    // Next enabled channel strictly above the current pointer, if any.
    always_comb begin
        higher_ptr = '0;
        has_higher = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (smask[i] && (i > int'(ptr))) begin
                higher_ptr = i[SELW-1:0];
                has_higher = 1'b1;
            end
        end
    end

    // Hold register capture on accept, release on load.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            hreg  <= '0;
            hmask <= '0;
            hfull <= 1'b0;
        end else if (accept) begin
            hreg  <= bus.in_data;
            hmask <= bus.mask;
            hfull <= 1'b1;
        end else if (load) begin
            hfull <= 1'b0;
        end
    end

    // Shift register load and channel pointer advance.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sreg  <= '0;
            smask <= '0;
            ptr   <= '0;
        end else if (load) begin
            sreg  <= hreg;
            smask <= hmask;
            ptr   <= first_ptr;
        end else if (shifting && !last) begin
            ptr   <= higher_ptr;
        end
    end

    // Control FSM: IDLE until a word is held, SHIFT while a word is presented.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= ST_IDLE;
        end else if (load) begin
            state <= ST_SHIFT;
        end else if (last) begin
            state <= ST_IDLE;
        end
    end

    // Outputs are forced to zero whenever no channel write is live, so the
    // demux drives all-zero outputs between and around words.
    assign bus.in_ready = !hfull;
    assign bus.strobe   = live;
    assign bus.sel      = live ? ptr : '0;
    assign bus.d        = live ? sreg[ptr] : 1'b0;
    assign bus.done     = last;
    assign bus.busy     = shifting;

    assign dbg_state    = state;
    assign dbg_hfull    = hfull;

endmodule
